// File: rtl/bit_lpf_scheduler_pkg.sv
// Shared types and sizing helpers for the 1-bit low-pass filter scheduler.
package bit_lpf_scheduler_pkg;

  // Sweep sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Default channel count and the matching channel-index width.
  localparam int CHANNELS_DEF = 8;

  // Width of the channel index: clog2 of the channel count, never below 1.
  function automatic int idx_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  localparam int IDX_W_DEF = idx_width(CHANNELS_DEF);

endpackage

// File: rtl/bit_lpf_scheduler_rate_tick_gen.sv
// Sweep-rate prescaler: a down-counter that issues a one-cycle tick every
// rateDiv+1 enabled cycles. rateDiv is only looked at when the counter reloads,
// so a change mid-count takes effect on the following period.
module rate_tick_gen #(
  parameter int DIV_BITS = 16
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                en,
  input  logic [DIV_BITS-1:0] rateDiv,
  output logic                tick
);

  logic [DIV_BITS-1:0] divCnt;

  // Resetting to zero makes the first enabled cycle after reset a tick.
  assign tick = en && (divCnt == '0);

  // Count down while enabled, reload on tick, hold while disabled.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      divCnt <= '0;
    end else if (tick) begin
      divCnt <= rateDiv;
    end else if (en) begin
      divCnt <= divCnt - 1'b1;
    end
  end

endmodule

// File: rtl/bit_lpf_scheduler.sv
// Time-multiplexed bank of 1-bit low-pass filters. Each prescaler tick
// snapshots the channel inputs and enables, then one shared adder walks the
// channels one per cycle, and the accumulator MSBs are published together
// with a one-cycle done pulse once the last channel has been updated.
module bit_lpf_scheduler #(
  parameter int CHANNELS  = 8,
  parameter int FILT_BITS = 8,
  parameter int DIV_BITS  = 16
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                en,
  input  logic [DIV_BITS-1:0] rateDiv,
  input  logic [CHANNELS-1:0] chEn,
  input  logic [CHANNELS-1:0] dataIn,
  input  logic                clrOverrun,
  output logic [CHANNELS-1:0] dataOut,
  output logic                done,
  output logic                busy,
  output logic                overrun
);

  import bit_lpf_scheduler_pkg::*;

  localparam int                IDX_W    = idx_width(CHANNELS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(CHANNELS - 1);

  state_t                state;
  state_t                state_nxt;
  logic                  tick;
  logic [IDX_W-1:0]      idx;
  logic [CHANNELS-1:0]   snap;
  logic [CHANNELS-1:0]   snapEn;
  logic [CHANNELS-1:0]   msb_q;
  logic [CHANNELS-1:0]   msb_nxt;
  logic [FILT_BITS-1:0]  acc [CHANNELS];
  logic [FILT_BITS-1:0]  acc_cur;
  logic [FILT_BITS-1:0]  acc_nxt;
  logic                  run_step;
  logic                  last_step;
  logic                  take_tick;
  logic                  drop_tick;

  rate_tick_gen #(
    .DIV_BITS (DIV_BITS)
  ) u_tick (
    .clk     (clk),
    .rstN    (rstN),
    .en      (en),
    .rateDiv (rateDiv),
    .tick    (tick)
  );

  // Sweep state register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-state strobes; ticks outside IDLE are dropped.
  always_comb begin
    state_nxt = state;
    run_step  = 1'b0;
    last_step = 1'b0;
    take_tick = 1'b0;
    drop_tick = 1'b0;
    done      = 1'b0;
    busy      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (tick) begin
          take_tick = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        busy      = 1'b1;
        run_step  = 1'b1;
        drop_tick = tick;
        if (idx == LAST_IDX) begin
          last_step = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        drop_tick = tick;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Shared update: acc + x - y with x the snapped input and y the current
  // output bit. Wraps modulo 2^FILT_BITS, but the state is bounded by
  // 2^(FILT_BITS-1) so it never actually overflows.
  assign acc_cur = acc[idx];
  assign acc_nxt = acc_cur + FILT_BITS'(snap[idx]) - FILT_BITS'(acc_cur[FILT_BITS-1]);

  // MSB shadow with the current channel's fresh value merged in, so the
  // last channel's update is visible in the published vector.
  always_comb begin
    msb_nxt = msb_q;
    if (snapEn[idx]) begin
      msb_nxt[idx] = acc_nxt[FILT_BITS-1];
    end
  end

  // Snapshot of inputs/mask at tick, then channel index walk.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      idx    <= '0;
      snap   <= '0;
      snapEn <= '0;
    end else if (take_tick) begin
      idx    <= '0;
      snap   <= dataIn;
      snapEn <= chEn;
    end else if (run_step) begin
      idx <= last_step ? '0 : idx + 1'b1;
    end
  end

  // Accumulator array, one entry written per RUN cycle.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int c = 0; c < CHANNELS; c++) begin
        acc[c] <= '0;
      end
    end else if (run_step && snapEn[idx]) begin
      acc[idx] <= acc_nxt;
    end
  end

  // Registered copy of every accumulator MSB, tracked as channels update.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      msb_q <= '0;
    end else if (run_step) begin
      msb_q <= msb_nxt;
    end
  end

  // Publish all filtered bits at once when the last channel is processed.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      dataOut <= '0;
    end else if (last_step) begin
      dataOut <= msb_nxt;
    end
  end

  // Sticky overrun: a dropped tick sets it and outranks a clear request.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      overrun <= 1'b0;
    end else if (drop_tick) begin
      overrun <= 1'b1;
    end else if (clrOverrun) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bit_lpf_scheduler.sv
// Self-checking bench for bit_lpf_scheduler (4 channels, 4-bit accumulators).
// A transaction-level model computes each sweep's result at its tick and
// queues it; the queue is popped whenever the DUT pulses done.
module tb_bit_lpf_scheduler;

  localparam int C  = 4;
  localparam int FB = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rstN;
  logic          en;
  logic [DW-1:0] rateDiv;
  logic [C-1:0]  chEn;
  logic [C-1:0]  dataIn;
  logic          clrOverrun;
  logic [C-1:0]  dataOut;
  logic          done;
  logic          busy;
  logic          overrun;

  always #5 clk = ~clk;

  bit_lpf_scheduler #(
    .CHANNELS  (C),
    .FILT_BITS (FB),
    .DIV_BITS  (DW)
  ) dut (
    .clk        (clk),
    .rstN       (rstN),
    .en         (en),
    .rateDiv    (rateDiv),
    .chEn       (chEn),
    .dataIn     (dataIn),
    .clrOverrun (clrOverrun),
    .dataOut    (dataOut),
    .done       (done),
    .busy       (busy),
    .overrun    (overrun)
  );

  int checks = 0;
  int errors = 0;

  // Model state
  logic [C-1:0]  sb_q [$];
  logic [FB-1:0] macc [C];
  int            mdiv;
  int            ph;        // 0 idle, 1..C sweep cycle, C+1 done cycle
  logic          movr;
  logic [C-1:0]  mout;
  int            cyc;
  int            done_cnt;
  int            first_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mdiv = 0;
    ph   = 0;
    movr = 1'b0;
    mout = '0;
    for (int c = 0; c < C; c++) macc[c] = '0;
    sb_q.delete();
  endtask

  // Entered and left at posedge+1: drive, sample at negedge, advance model.
  task automatic step(input bit toggle, input bit clr_on_drop, input bit clr_force);
    bit           tk;
    logic [C-1:0] res;
    logic [C-1:0] exp_out;
    tk = en && (mdiv == 0);
    if (toggle) dataIn = ~dataIn;
    clrOverrun = clr_force || (clr_on_drop && tk && (ph != 0));
    @(negedge clk);
    chk("busy", busy, (ph != 0));
    chk("done", done, (ph == C + 1));
    chk("overrun", overrun, movr);
    chk("dataOut_hold", dataOut, mout);
    if (done) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_out = sb_q.pop_front();
        chk("dataOut_sweep", dataOut, exp_out);
      end
      if (first_done < 0) first_done = cyc;
      done_cnt++;
    end
    // model clock edge
    if (tk && ph != 0) movr = 1'b1;
    else if (clrOverrun) movr = 1'b0;
    if (ph == 0) begin
      if (tk) begin
        for (int c = 0; c < C; c++) begin
          if (chEn[c]) macc[c] = macc[c] + FB'(dataIn[c]) - FB'(macc[c][FB-1]);
          res[c] = macc[c][FB-1];
        end
        sb_q.push_back(res);
        ph = 1;
      end
    end else if (ph == C + 1) begin
      ph = 0;
    end else begin
      if (ph == C && sb_q.size() > 0) mout = sb_q[0];
      ph++;
    end
    if (tk) mdiv = int'(rateDiv);
    else if (en) mdiv--;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_cycles(input int n, input bit toggle, input bit clr_on_drop);
    for (int i = 0; i < n; i++) step(toggle, clr_on_drop, 1'b0);
  endtask

  task automatic run_dones(input int n, input bit toggle);
    int target;
    int guard;
    target = done_cnt + n;
    guard  = 0;
    while (done_cnt < target && guard < 400) begin
      step(toggle, 1'b0, 1'b0);
      guard++;
    end
    if (done_cnt < target) chk("done_timeout", done_cnt, target);
  endtask

  task automatic step_until_ph(input int p);
    int guard;
    guard = 0;
    while (ph != p && guard < 100) begin
      step(1'b0, 1'b0, 1'b0);
      guard++;
    end
    if (ph != p) chk("ph_timeout", ph, p);
  endtask

  // Asserts reset at posedge+1, checks the asynchronous clear, releases later.
  task automatic apply_reset(input string tag);
    rstN = 1'b0;
    clrOverrun = 1'b0;
    model_reset();
    #1;
    chk({tag, "_dataOut"}, dataOut, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_overrun"}, overrun, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rstN       = 1'b1;
    cyc        = 0;
    done_cnt   = 0;
    first_done = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstN       = 1'b0;
    en         = 1'b1;
    rateDiv    = 16'd9;
    chEn       = 4'b1111;
    dataIn     = 4'b1111;
    clrOverrun = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    // All channels driven high: output flips on the 8th sweep
    apply_reset("rst0");
    run_dones(1, 1'b0);
    chk("first_done_cycle", first_done, 5);
    run_dones(6, 1'b0);
    chk("sweep7_out", dataOut, 4'b0000);
    run_dones(1, 1'b0);
    chk("sweep8_out", dataOut, 4'b1111);
    run_dones(2, 1'b0);
    chk("steady_out", dataOut, 4'b1111);

    // Masked channels stay at zero
    chEn = 4'b0101;
    apply_reset("rst1");
    run_dones(8, 1'b0);
    chk("mask_out", dataOut, 4'b0101);
    chk("mask_no_ovr", overrun, 0);

    // Tick period below the sweep length: drops, sticky flag, set wins
    chEn    = 4'b1111;
    rateDiv = 16'd3;
    apply_reset("rst2");
    run_cycles(6, 1'b0, 1'b0);
    chk("ovr_set", overrun, 1);
    run_cycles(16, 1'b0, 1'b1);
    chk("ovr_set_wins", overrun, 1);
    rateDiv = 16'd9;
    run_cycles(24, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("ovr_clear", overrun, 0);

    // Inputs toggling every cycle at the minimum overrun-free rate
    rateDiv = 16'd5;
    chEn    = 4'b1011;
    dataIn  = 4'b0110;
    apply_reset("rst3");
    run_dones(12, 1'b1);
    chk("toggle_no_ovr", overrun, 0);

    // Reset in the middle of a sweep, then restart from zero accumulators
    rateDiv = 16'd9;
    chEn    = 4'b1111;
    dataIn  = 4'b1111;
    apply_reset("rst4");
    run_dones(7, 1'b0);
    step_until_ph(3);
    apply_reset("rst_mid");
    run_dones(1, 1'b0);
    chk("post_reset_out", dataOut, 4'b0000);

    // Enable dropped mid-sweep: sweep finishes, then nothing until re-enabled
    begin
      int d0;
      step_until_ph(2);
      en = 1'b0;
      d0 = done_cnt;
      run_cycles(30, 1'b0, 1'b0);
      chk("en_off_one_done", done_cnt - d0, 1);
      chk("en_off_idle", busy, 0);
      en = 1'b1;
      run_dones(2, 1'b0);
      en = 1'b0;
      run_cycles(10, 1'b0, 1'b0);
      chk("sb_drain", sb_q.size(), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
